// File: rtl/mem_arbiter.sv
// Unified memory arbiter: shares one memory port between the CPU core and a DMA/loader.
// CPU has priority; DMA wins a tie once the CPU has taken DMA_WAIT_MAX grants in a row
// while DMA was waiting. Accesses are serialised with a fixed memory latency.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LAT      = 0,
  parameter int unsigned DMA_WAIT_MAX = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cpu_rd_i,
  input  logic          cpu_wr_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_ack_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          gnt_dma_o
);

  localparam logic [1:0] LatInit = 2'(MEM_LAT);
  localparam logic [3:0] WaitMax = 4'(DMA_WAIT_MAX);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e        state_q, state_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          gnt_dma_q, gnt_dma_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic cpu_req;
  logic dma_wins;
  logic done;
  logic cpu_done;
  logic dma_done;

  assign cpu_req  = cpu_rd_i | cpu_wr_i;
  assign dma_wins = dma_req_i & (~cpu_req | (starve_cnt_q == WaitMax));

  // Completion cycle; suppressed under reset so an abandoned access never acks.
  assign done     = (state_q == StAccess) & (lat_cnt_q == 2'd0) & ~reset_i;
  assign cpu_done = done & ~gnt_dma_q;
  assign dma_done = done & gnt_dma_q;

  // Handshake outputs and read-data steering
  always_comb begin
    cpu_stall_o = cpu_req & ~cpu_done & ~reset_i;
    cpu_rdata_o = cpu_done ? mem_rdata_i : '0;
    dma_ack_o   = dma_done;
    dma_rdata_o = dma_done ? mem_rdata_i : '0;
    mem_rd_o    = mem_rd_q;
    mem_wr_o    = mem_wr_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    gnt_dma_o   = gnt_dma_q;
  end

  // Arbitration and access sequencing
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    gnt_dma_d    = gnt_dma_q;
    mem_rd_d     = 1'b0;  // strobes live for the first access cycle only
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      StIdle: begin
        if (cpu_req || dma_req_i) begin
          state_d   = StAccess;
          lat_cnt_d = LatInit;
          if (dma_wins) begin
            gnt_dma_d    = 1'b1;
            mem_wr_d     = dma_we_i;
            mem_rd_d     = ~dma_we_i;
            mem_addr_d   = dma_addr_i;
            mem_wdata_d  = dma_wdata_i;
            starve_cnt_d = 4'd0;
          end else begin
            // Read+write together is a write
            gnt_dma_d   = 1'b0;
            mem_wr_d    = cpu_wr_i;
            mem_rd_d    = ~cpu_wr_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_wdata_i;
            if (!dma_req_i) begin
              starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != 4'd15) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      StAccess: begin
        if (lat_cnt_q == 2'd0) begin
          state_d   = StIdle;
          gnt_dma_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        gnt_dma_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      lat_cnt_q    <= 2'd0;
      starve_cnt_q <= 4'd0;
      gnt_dma_q    <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      gnt_dma_q    <= gnt_dma_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances share the stimulus and differ in
// MEM_LAT: index 0 -> 0, index 1 -> 2, index 2 -> 3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] cpu_rdata [3];
  logic        cpu_stall [3];
  logic        dma_ack   [3];
  logic [31:0] dma_rdata [3];
  logic        mem_rd    [3];
  logic        mem_wr    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        gnt_dma   [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT((g == 0) ? 0 : g + 1), .DMA_WAIT_MAX(4)
    ) u_dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .cpu_rd_i   (cpu_rd),
      .cpu_wr_i   (cpu_wr),
      .cpu_addr_i (cpu_addr),
      .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata[g]),
      .cpu_stall_o(cpu_stall[g]),
      .dma_req_i  (dma_req),
      .dma_we_i   (dma_we),
      .dma_addr_i (dma_addr),
      .dma_wdata_i(dma_wdata),
      .dma_ack_o  (dma_ack[g]),
      .dma_rdata_o(dma_rdata[g]),
      .mem_rd_o   (mem_rd[g]),
      .mem_wr_o   (mem_wr[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem_rdata),
      .gnt_dma_o  (gnt_dma[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
  endtask

  logic [5:0] order;

  initial begin
    // Reset state; a CPU request under reset must not stall
    clear_inputs();
    step();
    step();
    cpu_rd = 1'b1;
    cpu_addr = 32'h0000_0010;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk1($sformatf("rst_gnt%0d", g), gnt_dma[g], 1'b0);
      chk1($sformatf("rst_mem_rd%0d", g), mem_rd[g], 1'b0);
      chk1($sformatf("rst_mem_wr%0d", g), mem_wr[g], 1'b0);
      chk($sformatf("rst_mem_addr%0d", g), mem_addr[g], 32'h0);
      chk1($sformatf("rst_stall%0d", g), cpu_stall[g], 1'b0);
    end

    // CPU read, MEM_LAT=0
    step();
    reset = 1'b0;
    #1;
    chk1("t1_stall_req", cpu_stall[0], 1'b1);
    chk1("t1_mem_rd_req", mem_rd[0], 1'b0);
    step();
    mem_rdata = 32'h8C22_0004;
    #1;
    chk1("t1_mem_rd_c1", mem_rd[0], 1'b1);
    chk("t1_addr_c1", mem_addr[0], 32'h0000_0010);
    chk1("t1_stall_c1", cpu_stall[0], 1'b0);
    chk("t1_rdata_c1", cpu_rdata[0], 32'h8C22_0004);
    chk1("t1_gnt_c1", gnt_dma[0], 1'b0);
    step();
    cpu_rd = 1'b0;
    #1;
    chk1("t1_mem_rd_after", mem_rd[0], 1'b0);
    chk("t1_rdata_after", cpu_rdata[0], 32'h0);

    // DMA write, MEM_LAT=2
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("t2_gnt_req", gnt_dma[1], 1'b0);
    step();
    chk1("t2_gnt_c1", gnt_dma[1], 1'b1);
    chk1("t2_mem_wr_c1", mem_wr[1], 1'b1);
    chk1("t2_mem_rd_c1", mem_rd[1], 1'b0);
    chk("t2_addr_c1", mem_addr[1], 32'h40);
    chk("t2_wdata_c1", mem_wdata[1], 32'hDEAD_BEEF);
    chk1("t2_ack_c1", dma_ack[1], 1'b0);
    chk1("t2_stall_c1", cpu_stall[1], 1'b0);
    step();
    chk1("t2_mem_wr_c2", mem_wr[1], 1'b0);
    chk("t2_addr_c2", mem_addr[1], 32'h40);
    chk("t2_wdata_c2", mem_wdata[1], 32'hDEAD_BEEF);
    chk1("t2_ack_c2", dma_ack[1], 1'b0);
    chk1("t2_gnt_c2", gnt_dma[1], 1'b1);
    step();
    chk1("t2_ack_c3", dma_ack[1], 1'b1);
    chk1("t2_gnt_c3", gnt_dma[1], 1'b1);
    chk("t2_addr_c3", mem_addr[1], 32'h40);
    chk1("t2_stall_c3", cpu_stall[1], 1'b0);
    step();
    dma_req = 1'b0;
    #1;
    chk1("t2_ack_after", dma_ack[1], 1'b0);
    chk1("t2_gnt_after", gnt_dma[1], 1'b0);

    // Starvation guard, MEM_LAT=0: CPU x4, DMA, CPU
    do_reset();
    order = 6'b01_0000;
    cpu_rd = 1'b1; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    mem_rdata = 32'h0BAD_F00D;
    #1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk1($sformatf("t3_gnt%0d", k), gnt_dma[0], order[k]);
      chk1($sformatf("t3_ack%0d", k), dma_ack[0], order[k]);
      chk1($sformatf("t3_stall%0d", k), cpu_stall[0], order[k]);
      chk($sformatf("t3_addr%0d", k), mem_addr[0], order[k] ? 32'h80 : 32'h100);
      chk($sformatf("t3_cpu_rdata%0d", k), cpu_rdata[0], order[k] ? 32'h0 : 32'h0BAD_F00D);
      chk($sformatf("t3_dma_rdata%0d", k), dma_rdata[0], order[k] ? 32'h0BAD_F00D : 32'h0);
      step();
      if (k == 4) dma_req = 1'b0;
      #1;
    end
    cpu_rd = 1'b0;

    // CPU read+write together is a write, MEM_LAT=0
    do_reset();
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    #1;
    step();
    chk1("t4_mem_wr", mem_wr[0], 1'b1);
    chk1("t4_mem_rd", mem_rd[0], 1'b0);
    chk("t4_addr", mem_addr[0], 32'h20);
    chk("t4_wdata", mem_wdata[0], 32'h1234_5678);
    chk1("t4_stall", cpu_stall[0], 1'b0);
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    #1;
    chk1("t4_mem_wr_after", mem_wr[0], 1'b0);

    // Reset during a DMA read access, MEM_LAT=3
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100;
    #1;
    step();
    chk1("t5_gnt_c1", gnt_dma[2], 1'b1);
    chk1("t5_mem_rd_c1", mem_rd[2], 1'b1);
    chk("t5_addr_c1", mem_addr[2], 32'h100);
    reset = 1'b1;
    #1;
    chk1("t5_ack_in_rst", dma_ack[2], 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk1("t5_gnt_post_rst", gnt_dma[2], 1'b0);
    chk1("t5_mem_rd_post_rst", mem_rd[2], 1'b0);
    chk("t5_addr_post_rst", mem_addr[2], 32'h0);
    chk1("t5_ack_post_rst", dma_ack[2], 1'b0);
    step();
    chk1("t5_regnt", gnt_dma[2], 1'b1);
    chk1("t5_mem_rd_regnt", mem_rd[2], 1'b1);
    step();
    chk1("t5_ack_c2", dma_ack[2], 1'b0);
    chk1("t5_mem_rd_c2", mem_rd[2], 1'b0);
    step();
    chk1("t5_ack_c3", dma_ack[2], 1'b0);
    step();
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk1("t5_ack_c4", dma_ack[2], 1'b1);
    chk("t5_dma_rdata_c4", dma_rdata[2], 32'hCAFE_F00D);
    chk("t5_addr_c4", mem_addr[2], 32'h100);
    step();
    dma_req = 1'b0;
    #1;
    chk1("t5_ack_after", dma_ack[2], 1'b0);
    chk1("t5_gnt_after", gnt_dma[2], 1'b0);
    chk("t5_dma_rdata_after", dma_rdata[2], 32'h0);

    // DMA drops its request right after grant, MEM_LAT=2
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44;
    #1;
    step();
    dma_req = 1'b0;
    #1;
    chk1("t6_gnt_c1", gnt_dma[1], 1'b1);
    chk1("t6_mem_rd_c1", mem_rd[1], 1'b1);
    step();
    chk1("t6_ack_c2", dma_ack[1], 1'b0);
    step();
    mem_rdata = 32'h55AA_55AA;
    #1;
    chk1("t6_ack_c3", dma_ack[1], 1'b1);
    chk("t6_dma_rdata_c3", dma_rdata[1], 32'h55AA_55AA);
    chk("t6_cpu_rdata_c3", cpu_rdata[1], 32'h0);
    step();
    chk1("t6_gnt_idle", gnt_dma[1], 1'b0);
    chk1("t6_ack_idle", dma_ack[1], 1'b0);
    step();
    chk1("t6_gnt_no_regrant", gnt_dma[1], 1'b0);
    chk1("t6_mem_rd_no_regrant", mem_rd[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory (instruction fetch and data) between the multi-cycle CPU core and a DMA/loader port.
- Serialises accesses with a fixed, parameterised memory latency and stalls the CPU while its access is pending or blocked.
- Arbitration is CPU-priority with a starvation guard for DMA.
- Sits between the CPU's MemRd/MemWr/address mux and the memory; the top level gates the CPU's state-register and PC write enables with !cpu_stall.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 0, cycles from command cycle to valid read data (legal 0..3; 0 = combinational memory)
DMA_WAIT_MAX, 4, consecutive CPU grants allowed while dma_req is pending before DMA wins a tie (legal 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cpu_rd  in  1  CPU read request (MemRd)
cpu_wr  in  1  CPU write request (MemWr)
cpu_addr  in  AW  CPU address (post IorD mux)
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data to IR/MDR
cpu_stall  out  1  CPU must hold state and request
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1 = write, 0 = read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DW  read data, valid when dma_ack=1
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
gnt_dma  out  1  1 while the current access owner is DMA

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- States: IDLE, ACCESS.
- Reset values: state=IDLE; mem_rd=mem_wr=0; mem_addr=mem_wdata=0; dma_ack=0; gnt_dma=0; starvation counter=0. cpu_stall is forced to 0 while reset=1. Any in-flight access is abandoned with no ack.
- cpu_req = cpu_rd | cpu_wr. If both are high, the access is treated as a write.
- IDLE arbitration, at the clock edge:
  - only cpu_req → CPU wins.
  - only dma_req → DMA wins.
  - both → CPU wins unless starve_cnt == DMA_WAIT_MAX, in which case DMA wins.
- On a win: latch winner addr/wdata/op into the mem_* registers, set gnt_dma, load lat_cnt=MEM_LAT, go to ACCESS.
- Starvation counter:
  - CPU grant with dma_req=1 → increment (saturate at 15).
  - CPU grant with dma_req=0, or any DMA grant → clear.
- ACCESS timing:
  - First ACCESS cycle (C1): mem_rd or mem_wr = 1 for exactly this one cycle. mem_addr and mem_wdata are held stable for all of ACCESS.
  - lat_cnt decrements each cycle. The completion cycle is C1+MEM_LAT (C1 itself when MEM_LAT=0).
  - In the completion cycle, mem_rdata is passed combinationally to cpu_rdata or dma_rdata.
  - Next edge → IDLE and gnt_dma=0. No back-to-back arbitration from ACCESS, so throughput is 1 access per MEM_LAT+2 cycles.
- CPU handshake:
  - cpu_stall = cpu_req & !(ACCESS & owner=CPU & completion cycle). It is combinational, so the CPU advances on the completion edge.
  - The CPU holds its request fields stable while cpu_stall=1.
  - Latency from an idle arbiter is MEM_LAT+2 cycles including the request cycle (stall cycles = MEM_LAT+1).
- DMA handshake:
  - dma_ack = completion cycle & owner=DMA. It is a 1-cycle pulse, never asserted outside ACCESS.
  - DMA holds dma_req, dma_we, dma_addr and dma_wdata stable until dma_ack. It may re-request in the cycle after ack.
  - Fields are sampled only at the grant edge; changes after grant are ignored.
- cpu_rdata and dma_rdata are 0 outside their own completion cycle.
- A request dropped before grant is ignored. A request dropped after grant still completes; the ack/strobe still occurs.

Test Plan:
- Reset, then CPU read at addr 0x00000010 with MEM_LAT=0, mem returns 0x8C220004 → mem_rd high exactly 1 cycle with mem_addr=0x10; cpu_stall high 1 cycle; cpu_rdata=0x8C220004 in the completion cycle.
- MEM_LAT=2, DMA write addr 0x40 data 0xDEADBEEF → mem_wr 1 cycle, addr/data held 3 cycles, dma_ack pulse at C1+2, gnt_dma high 3 cycles; no CPU stall since CPU is idle.
- CPU and DMA request in the same cycle, DMA_WAIT_MAX=4, CPU re-requests continuously → grant order CPU,CPU,CPU,CPU,DMA,CPU; dma_ack occurs on the 5th access.
- CPU write with cpu_rd=cpu_wr=1, addr 0x20 data 0x12345678 → only mem_wr asserted, mem_rd stays 0.
- Assert reset during the ACCESS cycle of a DMA read (MEM_LAT=3) → mem_* strobes drop next edge, no dma_ack, gnt_dma=0; a DMA request held after reset is re-granted from IDLE and acks normally.
- DMA drops dma_req the cycle after its grant → access still completes with dma_ack; no second grant follows.
